apb_timer_irq_ctrl: RTL
=======================

// Module: apb_timer_irq_ctrl
// PURPOSE
//  Downstream of the APB timer unit: captures its irq_lo_o/irq_hi_o pulses (plus spare sources) into pending bits.
//  Applies a per-source mask and counts overruns.
//  Arbitrates pending sources into a req/ack interrupt handshake towards the core.
//  Software access is APB: mask, pending, set/clear and overrun counters.
// PARAMETERS
//  APB_ADDR_WIDTH  12  APB address width; only PADDR[5:0] is decoded
//  NB_SRC          4   number of irq sources (1..8); src 0 = timer lo, src 1 = timer hi
// PORTS
//  HCLK      in   1               single clock
//  HRESET    in   1               reset, synchronous, active-high
//  PADDR     in   APB_ADDR_WIDTH  APB address
//  PWDATA    in   32              APB write data
//  PWRITE    in   1               APB write
//  PSEL      in   1               APB select
//  PENABLE   in   1               APB enable
//  PRDATA    out  32              APB read data
//  PREADY    out  1               = PSEL & PENABLE (zero wait states)
//  PSLVERR   out  1               1 on access to an unmapped offset during the access phase
//  src_i     in   NB_SRC          irq sources; pulse or level, rising edge is the event
//  irq_req_o out  1               interrupt request to core
//  irq_id_o  out  3               index of the requested source; stable while irq_req_o = 1
//  irq_ack_i in   1               core accepts irq_id_o; ignored when irq_req_o = 0
//  irq_o     out  1               level output = |(pending & mask), for wake-up logic
// BEHAVIOUR
//  Reset: all registers 0, including src_q, mask, pending, overrun counters and req; all outputs 0.
//   A source that is high at reset release counts as a rising edge.
//  Edge detect: rise[i] = src_i[i] & ~src_q[i]; src_q is registered every cycle.
//  Register map (PADDR[5:0]); writes commit at PSEL&PENABLE&PWRITE:
//   0x00 MASK     RW  bits [NB_SRC-1:0]; upper bits read 0
//   0x04 PENDING  RO
//   0x08 SET      WO  pending |= PWDATA
//   0x0C CLEAR    WO  pending &= ~PWDATA
//   0x10 STATUS   RO  {irq_req_o at bit 31, irq_id_o in [2:0]}
//   0x20+4*i      overrun counter i; 8-bit in [7:0]; RO value, any write clears it. Valid only for i < NB_SRC.
//   Any other offset returns PRDATA = 0 and PSLVERR = 1. Write-only regs read 0 without error.
//   PRDATA = 0 outside a read access phase.
//  Pending next-state: (pending | rise | set) & ~(clear | ack_clr), with rise taking precedence.
//   A hardware edge in the same cycle as a SW clear or ack of that bit leaves pending = 1, so no event is lost.
//  Overrun: rise[i] while pending[i] = 1 and pending[i] not cleared this cycle -> cnt[i] += 1.
//   Counter saturates at 255. A SW write-clear in the same cycle wins and the counter becomes 0.
//  Latency: rise at cycle t -> pending at t+1 -> irq_req_o at t+2 (if masked in and arbiter idle).
//  Arbiter FSM:
//   IDLE: if |(pending & mask), latch the lowest pending&mask index into irq_id_o and go to REQ (req = 1).
//   REQ, irq_ack_i = 1: clear pending[irq_id_o] in that cycle, go to IDLE; req = 0 for at least 1 cycle.
//   REQ, pending[id] & mask[id] drops without ack (SW clear or mask): withdraw, go to IDLE next cycle. No id change while in REQ.
//   REQ, irq_ack_i together with withdrawal: treat as ack.
//  Reset mid-handshake: return to IDLE immediately; a late ack after reset is ignored.
// STRUCTURE
//  Package timer_irq_pkg:
//   register offset localparams (MASK..OVR_BASE), OVR_W = 8, ID_W = 3
//   arbiter state enum {IDLE, REQ}
//  Sub-module irq_src_slice, generated NB_SRC times:
//   edge detect, pending bit, saturating overrun counter
//   inputs set/clr/ack_clr/ovr_clr; outputs pending, cnt
//  Top level holds the APB decode, mask register, lowest-index priority encoder and arbiter FSM.
// TESTING
//  1-cycle pulse on src_i[0], mask = 0x1:
//   PENDING = 0x1 at t+1, irq_req_o = 1 with id = 0 at t+2.
//   ack -> pending 0, req 0 next cycle.
//  mask = 0xF, pulses on src 1 and 3 in the same cycle:
//   id = 1 first; after ack, req drops for 1 cycle, then id = 3.
//  src 2 unmasked, 300 pulses while pending stays 1:
//   counter read at 0x28 gives 255; write to 0x28 -> reads 0.
//  SW write CLEAR = 0x1 in the same cycle as a src 0 rise:
//   PENDING[0] stays 1 and the overrun count is unchanged.
//  In REQ with id = 1, clear MASK bit 1 -> req withdrawn next cycle, no pending cleared.
//   Then write SET = 0x4 with mask 0x4 -> req with id = 2.
//  Read 0x18 -> PSLVERR = 1, PRDATA = 0.
//   Assert HRESET during REQ -> all outputs 0 next cycle.

Source files
------------

// File: rtl/timer_irq_pkg.sv
// Shared constants, arbiter state and priority helper
// for the timer interrupt controller.
package timer_irq_pkg;

    localparam logic [5:0] MASK_OFF = 6'h00;
    localparam logic [5:0] PEND_OFF = 6'h04;
    localparam logic [5:0] SET_OFF  = 6'h08;
    localparam logic [5:0] CLR_OFF  = 6'h0C;
    localparam logic [5:0] STAT_OFF = 6'h10;
    localparam logic [5:0] OVR_BASE = 6'h20;

    localparam int OVR_W = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE,
        REQ
    } arb_state_e;

    // Lowest set bit wins
    function automatic logic [ID_W-1:0] lowest_idx(input logic [7:0] v);
        lowest_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/irq_src_slice.sv
// One interrupt source: edge detect, pending bit and
// saturating overrun counter.
module irq_src_slice
    import timer_irq_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             src,
    input  logic             set,
    input  logic             clr,
    input  logic             ack_clr,
    input  logic             ovr_clr,
    output logic             pending,
    output logic [OVR_W-1:0] cnt
);

    logic src_q;
    logic rise;
    logic drop;
    logic ovr;

    assign rise = src & ~src_q;
    assign drop = clr | ack_clr;
    assign ovr  = rise & pending & ~drop;

    // A fresh edge overrides any clear so the event is kept
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            src_q   <= 1'b0;
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            src_q   <= src;
            pending <= rise | ((pending | set) & ~drop);
            if (ovr_clr) begin
                cnt <= '0;
            end else if (ovr && cnt != '1) begin
                cnt <= cnt + OVR_W'(1);
            end
        end
    end

endmodule

// File: rtl/apb_timer_irq_ctrl.sv
// APB-programmed interrupt controller behind the timer:
// register decode, mask, priority pick and req/ack arbiter.
module apb_timer_irq_ctrl
    import timer_irq_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_SRC         = 4
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NB_SRC-1:0]         src_i,
    output logic                      irq_req_o,
    output logic [ID_W-1:0]           irq_id_o,
    input  logic                      irq_ack_i,
    output logic                      irq_o
);

    logic              acc;
    logic              wr;
    logic [5:0]        off;
    logic              hit;
    logic [31:0]       rdata;
    logic [NB_SRC-1:0] mask_q;
    logic [NB_SRC-1:0] pending;
    logic [NB_SRC-1:0] set_v;
    logic [NB_SRC-1:0] clr_v;
    logic [NB_SRC-1:0] ovr_sel;
    logic [NB_SRC-1:0] ovr_clr;
    logic [NB_SRC-1:0] ack_clr;
    logic [NB_SRC-1:0] act;
    logic [7:0]        act8;
    logic [OVR_W-1:0]  cnt [NB_SRC];
    logic              ack_fire;
    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   id_d;
    logic              unused_bits;

    assign unused_bits = ^{PADDR[APB_ADDR_WIDTH-1:6], PWDATA[31:NB_SRC]};

    assign off    = PADDR[5:0];
    assign acc    = PSEL & PENABLE;
    assign wr     = acc & PWRITE;
    assign PREADY = acc;

    assign set_v   = (wr && off == SET_OFF) ? PWDATA[NB_SRC-1:0] : '0;
    assign clr_v   = (wr && off == CLR_OFF) ? PWDATA[NB_SRC-1:0] : '0;
    assign ovr_clr = wr ? ovr_sel : '0;

    assign act      = pending & mask_q;
    assign ack_fire = (state_q == REQ) & irq_ack_i;

    always_comb begin
        act8 = '0;
        act8[NB_SRC-1:0] = act;
    end

    for (genvar i = 0; i < NB_SRC; i++) begin : g_src
        assign ovr_sel[i] = (off == OVR_BASE + 6'(4 * i));
        assign ack_clr[i] = ack_fire & (id_q == ID_W'(i));

        irq_src_slice u_slice (
            .HCLK    (HCLK),
            .HRESET  (HRESET),
            .src     (src_i[i]),
            .set     (set_v[i]),
            .clr     (clr_v[i]),
            .ack_clr (ack_clr[i]),
            .ovr_clr (ovr_clr[i]),
            .pending (pending[i]),
            .cnt     (cnt[i])
        );
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mask_q <= '0;
        end else if (wr && off == MASK_OFF) begin
            mask_q <= PWDATA[NB_SRC-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        hit   = 1'b1;
        case (off)
            MASK_OFF: rdata[NB_SRC-1:0] = mask_q;
            PEND_OFF: rdata[NB_SRC-1:0] = pending;
            SET_OFF, CLR_OFF: rdata = '0;
            STAT_OFF: begin
                rdata[31]         = irq_req_o;
                rdata[ID_W-1:0]   = id_q;
            end
            default: begin
                hit = |ovr_sel;
                for (int i = 0; i < NB_SRC; i++) begin
                    if (ovr_sel[i]) rdata[OVR_W-1:0] = cnt[i];
                end
            end
        endcase
    end

    assign PRDATA  = (acc && !PWRITE && hit) ? rdata : '0;
    assign PSLVERR = acc & ~hit;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // id is frozen for the whole REQ phase; ack beats withdrawal
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (|act) begin
                    state_d = REQ;
                    id_d    = lowest_idx(act8);
                end
            end
            REQ: begin
                if (irq_ack_i || !act8[id_q]) state_d = IDLE;
            end
        endcase
    end

    assign irq_req_o = (state_q == REQ);
    assign irq_id_o  = id_q;
    assign irq_o     = |act;

endmodule
